// File: rtl/eeprom_emu_pkg.sv
// Shared types and constants for the I2C EEPROM emulation controller.
package eeprom_emu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DEV    = 3'd1,
    ST_WADDR  = 3'd2,
    ST_WDATA  = 3'd3,
    ST_RDATA  = 3'd4,
    ST_IGNORE = 3'd5
  } eeprom_state_t;

  localparam logic [6:0] EEPROM_DEV_ADDR_DEFAULT = 7'h50;

endpackage

// File: rtl/eeprom_emu_ram.sv
// Single-port synchronous byte RAM, one-cycle read latency, write-first output.
module eeprom_emu_ram #(
  parameter int MEM_DEPTH = 256
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         we,
  input  logic [$clog2(MEM_DEPTH)-1:0] addr,
  input  logic [7:0]                   wdata,
  output logic [7:0]                   q
);

  logic [7:0] mem_r [MEM_DEPTH];
  logic [7:0] q_r;

  // Storage array; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end
  end

  // Read register, returns the written byte on a write cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      q_r <= 8'h00;
    end else if (we) begin
      q_r <= wdata;
    end else begin
      q_r <= mem_r[addr];
    end
  end

  assign q = q_r;

endmodule

// File: rtl/eeprom_emu_ctrl.sv
// AT24-style EEPROM emulation behind an I2C slave byte engine, sharing the
// memory with a local host port; the I2C side always has priority.
module eeprom_emu_ctrl
  import eeprom_emu_pkg::*;
#(
  parameter int         MEM_DEPTH = 256,
  parameter int         PAGE_SIZE = 16,
  parameter logic [6:0] DEV_ADDR  = EEPROM_DEV_ADDR_DEFAULT,
  parameter int         WR_CYCLE  = 5000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i2c_start,
  input  logic                         i2c_stop,
  input  logic                         i2c_rx_valid,
  input  logic [7:0]                   i2c_rx_data,
  output logic                         i2c_ack,
  input  logic                         i2c_tx_req,
  input  logic                         i2c_tx_nack,
  output logic                         i2c_tx_valid,
  output logic [7:0]                   i2c_tx_data,
  input  logic                         host_req,
  input  logic                         host_we,
  input  logic [$clog2(MEM_DEPTH)-1:0] host_addr,
  input  logic [7:0]                   host_wdata,
  output logic                         host_gnt,
  output logic                         host_rvalid,
  output logic [7:0]                   host_rdata,
  output logic                         busy
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam int CW = $clog2(WR_CYCLE + 1);
  localparam logic [AW-1:0] PAGE_MASK = AW'(PAGE_SIZE - 1);

  eeprom_state_t state_r;
  logic [AW-1:0] ptr_r;
  logic          ack_r;
  logic          wrote_r;
  logic          wr_pend_r;
  logic [AW-1:0] wr_addr_r;
  logic [7:0]    wr_data_r;
  logic          rd_pend_r;
  logic          tx_valid_r;
  logic [7:0]    tx_data_r;
  logic          rvalid_r;
  logic [CW-1:0] cnt_r;
  logic          busy_r;

  logic          i2c_rd_s;
  logic          host_gnt_s;
  logic          ram_we_s;
  logic [AW-1:0] ram_addr_s;
  logic [7:0]    ram_wdata_s;
  logic [7:0]    ram_q_s;

  // Page-write increment: only the in-page bits advance, upper bits stay put.
  function automatic logic [AW-1:0] page_inc(input logic [AW-1:0] p);
    return (p & ~PAGE_MASK) | ((p + AW'(1)) & PAGE_MASK);
  endfunction

  assign i2c_rd_s   = (state_r == ST_RDATA) && i2c_tx_req && !i2c_start && !i2c_stop;
  assign host_gnt_s = host_req && !wr_pend_r && !i2c_rd_s;

  // Memory port mux: pending I2C write, then I2C read, then host.
  always_comb begin
    ram_we_s    = 1'b0;
    ram_addr_s  = host_addr;
    ram_wdata_s = host_wdata;
    if (wr_pend_r) begin
      ram_we_s    = 1'b1;
      ram_addr_s  = wr_addr_r;
      ram_wdata_s = wr_data_r;
    end else if (i2c_rd_s) begin
      ram_addr_s  = ptr_r;
    end else if (host_gnt_s) begin
      ram_we_s    = host_we;
    end else begin
      ram_we_s    = 1'b0;
    end
  end

  eeprom_emu_ram #(.MEM_DEPTH(MEM_DEPTH)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we_s),
    .addr  (ram_addr_s),
    .wdata (ram_wdata_s),
    .q     (ram_q_s)
  );

  // I2C protocol FSM with pointer, busy timer and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      ptr_r      <= {AW{1'b0}};
      ack_r      <= 1'b0;
      wrote_r    <= 1'b0;
      wr_pend_r  <= 1'b0;
      wr_addr_r  <= {AW{1'b0}};
      wr_data_r  <= 8'h00;
      rd_pend_r  <= 1'b0;
      tx_valid_r <= 1'b0;
      tx_data_r  <= 8'h00;
      rvalid_r   <= 1'b0;
      cnt_r      <= {CW{1'b0}};
      busy_r     <= 1'b0;
    end else begin
      wr_pend_r  <= 1'b0;
      rd_pend_r  <= i2c_rd_s;
      tx_valid_r <= rd_pend_r;
      rvalid_r   <= host_gnt_s && !host_we;
      if (rd_pend_r) begin
        tx_data_r <= ram_q_s;
      end
      if (cnt_r != {CW{1'b0}}) begin
        cnt_r  <= cnt_r - CW'(1);
        busy_r <= (cnt_r > CW'(1));
      end

      if (i2c_start) begin
        state_r <= ST_DEV;
        ack_r   <= 1'b0;
        wrote_r <= 1'b0;
      end else if (i2c_stop) begin
        state_r <= ST_IDLE;
        ack_r   <= 1'b0;
        wrote_r <= 1'b0;
        if (wrote_r) begin
          cnt_r  <= CW'(WR_CYCLE);
          busy_r <= 1'b1;
        end
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (i2c_rx_valid) ack_r <= 1'b0;
          end
          ST_DEV: begin
            if (i2c_rx_valid) begin
              if ((i2c_rx_data[7:1] != DEV_ADDR) || busy_r) begin
                ack_r   <= 1'b0;
                state_r <= ST_IGNORE;
              end else begin
                ack_r   <= 1'b1;
                state_r <= i2c_rx_data[0] ? ST_RDATA : ST_WADDR;
              end
            end
          end
          ST_WADDR: begin
            if (i2c_rx_valid) begin
              ptr_r   <= i2c_rx_data[AW-1:0];
              ack_r   <= 1'b1;
              state_r <= ST_WDATA;
            end
          end
          ST_WDATA: begin
            if (i2c_rx_valid) begin
              wr_pend_r <= 1'b1;
              wr_addr_r <= ptr_r;
              wr_data_r <= i2c_rx_data;
              ack_r     <= 1'b1;
              wrote_r   <= 1'b1;
              ptr_r     <= page_inc(ptr_r);
            end
          end
          ST_RDATA: begin
            if (i2c_tx_req) ptr_r <= ptr_r + AW'(1);
            if (i2c_tx_nack) state_r <= ST_IGNORE;
          end
          ST_IGNORE: begin
            if (i2c_rx_valid) ack_r <= 1'b0;
          end
          default: begin
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign i2c_ack      = ack_r;
  assign i2c_tx_valid = tx_valid_r;
  assign i2c_tx_data  = tx_data_r;
  assign host_gnt     = host_gnt_s;
  assign host_rvalid  = rvalid_r;
  assign host_rdata   = ram_q_s;
  assign busy         = busy_r;

endmodule

// File: tb/tb_eeprom_emu_ctrl.sv
// Directed self-checking bench for eeprom_emu_ctrl with a short write cycle.
module tb_eeprom_emu_ctrl;

  localparam int W = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       i2c_start = 1'b0, i2c_stop = 1'b0, i2c_rx_valid = 1'b0;
  logic [7:0] i2c_rx_data = 8'h00;
  logic       i2c_ack;
  logic       i2c_tx_req = 1'b0, i2c_tx_nack = 1'b0;
  logic       i2c_tx_valid;
  logic [7:0] i2c_tx_data;
  logic       host_req = 1'b0, host_we = 1'b0;
  logic [7:0] host_addr = 8'h00, host_wdata = 8'h00;
  logic       host_gnt, host_rvalid;
  logic [7:0] host_rdata;
  logic       busy;

  int total = 0;
  int bad   = 0;

  eeprom_emu_ctrl #(.MEM_DEPTH(256), .PAGE_SIZE(16), .DEV_ADDR(7'h50), .WR_CYCLE(W)) dut (
    .clk(clk), .rst(rst),
    .i2c_start(i2c_start), .i2c_stop(i2c_stop),
    .i2c_rx_valid(i2c_rx_valid), .i2c_rx_data(i2c_rx_data), .i2c_ack(i2c_ack),
    .i2c_tx_req(i2c_tx_req), .i2c_tx_nack(i2c_tx_nack),
    .i2c_tx_valid(i2c_tx_valid), .i2c_tx_data(i2c_tx_data),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic start_c();
    @(negedge clk); i2c_start = 1'b1;
    @(negedge clk); i2c_start = 1'b0;
  endtask

  task automatic stop_c();
    @(negedge clk); i2c_stop = 1'b1;
    @(negedge clk); i2c_stop = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input logic exp_ack, input string tag);
    @(negedge clk); i2c_rx_valid = 1'b1; i2c_rx_data = b;
    @(negedge clk); i2c_rx_valid = 1'b0;
    chk(tag, i2c_ack, exp_ack);
  endtask

  task automatic tx_read(input logic [7:0] exp, input string tag);
    @(negedge clk); i2c_tx_req = 1'b1;
    @(negedge clk); i2c_tx_req = 1'b0;
    chk({tag, "_early"}, i2c_tx_valid, 1'b0);
    @(negedge clk);
    chk({tag, "_valid"}, i2c_tx_valid, 1'b1);
    chk(tag, i2c_tx_data, exp);
  endtask

  task automatic nack_c();
    @(negedge clk); i2c_tx_nack = 1'b1;
    @(negedge clk); i2c_tx_nack = 1'b0;
  endtask

  task automatic wait_gnt();
    int n;
    n = 0;
    #1;
    while (!host_gnt && n < 50) begin
      @(negedge clk); #1; n++;
    end
    chk("host_gnt_wait", host_gnt, 1'b1);
  endtask

  task automatic host_wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk); host_req = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d;
    wait_gnt();
    @(negedge clk); host_req = 1'b0; host_we = 1'b0;
  endtask

  task automatic host_rd(input logic [7:0] a, input logic [7:0] exp, input string tag);
    @(negedge clk); host_req = 1'b1; host_we = 1'b0; host_addr = a;
    wait_gnt();
    @(negedge clk); host_req = 1'b0;
    chk({tag, "_rvalid"}, host_rvalid, 1'b1);
    chk(tag, host_rdata, exp);
  endtask

  task automatic wait_busy_clear();
    for (int i = 0; i < W + 10 && busy; i++) @(negedge clk);
    chk("busy_clear", busy, 1'b0);
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_ack"}, i2c_ack, 1'b0);
    chk({tag, "_txv"}, i2c_tx_valid, 1'b0);
    chk({tag, "_txd"}, i2c_tx_data, 8'h00);
    chk({tag, "_gnt"}, host_gnt, 1'b0);
    chk({tag, "_rv"}, host_rvalid, 1'b0);
    chk({tag, "_rd"}, host_rdata, 8'h00);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check_reset_outs("rst0");
    rst = 1'b1;

    // Byte write and write-cycle length
    start_c();
    send(8'hA0, 1'b1, "bw_dev");
    send(8'h05, 1'b1, "bw_waddr");
    send(8'h3C, 1'b1, "bw_data");
    stop_c();
    n = 0;
    while (busy && n < W + 10) begin n++; @(negedge clk); end
    chk("bw_busy_len", n, W);
    host_wr(8'h06, 8'h7A);
    host_rd(8'h05, 8'h3C, "bw_mem5");

    // Random read, then a read-only STOP must not start a write cycle
    start_c();
    send(8'hA0, 1'b1, "rr_dev");
    send(8'h05, 1'b1, "rr_waddr");
    start_c();
    send(8'hA1, 1'b1, "rr_devr");
    tx_read(8'h3C, "rr_b0");
    tx_read(8'h7A, "rr_b1");
    nack_c();
    stop_c();
    chk("rr_nobusy", busy, 1'b0);

    // Page wrap, then ACK polling while the write cycle runs
    host_wr(8'h10, 8'h55);
    start_c();
    send(8'hA0, 1'b1, "pw_dev");
    send(8'h0E, 1'b1, "pw_waddr");
    send(8'h01, 1'b1, "pw_d1");
    send(8'h02, 1'b1, "pw_d2");
    send(8'h03, 1'b1, "pw_d3");
    send(8'h04, 1'b1, "pw_d4");
    stop_c();
    chk("pw_busy", busy, 1'b1);
    start_c();
    send(8'hA0, 1'b0, "poll_nack");
    send(8'h0E, 1'b0, "poll_ignore");
    stop_c();
    wait_busy_clear();
    start_c();
    send(8'hA0, 1'b1, "poll_ack");
    stop_c();
    chk("poll_nobusy", busy, 1'b0);
    host_rd(8'h0E, 8'h01, "pw_0e");
    host_rd(8'h0F, 8'h02, "pw_0f");
    host_rd(8'h00, 8'h03, "pw_00");
    host_rd(8'h01, 8'h04, "pw_01");
    host_rd(8'h10, 8'h55, "pw_10_untouched");

    // Wrong device address
    start_c();
    send(8'hA2, 1'b0, "wa_dev");
    send(8'h05, 1'b0, "wa_b1");
    send(8'h99, 1'b0, "wa_b2");
    stop_c();
    chk("wa_nobusy", busy, 1'b0);
    host_rd(8'h05, 8'h3C, "wa_mem5");

    // Arbitration: host write held across back-to-back I2C data bytes
    start_c();
    send(8'hA0, 1'b1, "arb_dev");
    send(8'h20, 1'b1, "arb_waddr");
    @(negedge clk); i2c_rx_valid = 1'b1; i2c_rx_data = 8'hD0;
    @(negedge clk); i2c_rx_data = 8'hD1;
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h10; host_wdata = 8'hC5;
    #1 chk("arb_blk1", host_gnt, 1'b0);
    @(negedge clk); i2c_rx_data = 8'hD2;
    #1 chk("arb_blk2", host_gnt, 1'b0);
    @(negedge clk); i2c_rx_data = 8'hD3;
    #1 chk("arb_blk3", host_gnt, 1'b0);
    @(negedge clk); i2c_rx_valid = 1'b0;
    #1 chk("arb_blk4", host_gnt, 1'b0);
    @(negedge clk);
    #1 chk("arb_gnt", host_gnt, 1'b1);
    @(negedge clk); host_req = 1'b0; host_we = 1'b0;
    stop_c();
    wait_busy_clear();
    host_rd(8'h10, 8'hC5, "arb_host");
    host_rd(8'h20, 8'hD0, "arb_i2c0");
    host_rd(8'h23, 8'hD3, "arb_i2c3");

    // Reset after the word address: abort, IDLE, no write
    host_wr(8'h40, 8'h11);
    start_c();
    send(8'hA0, 1'b1, "rm_dev");
    send(8'h40, 1'b1, "rm_waddr");
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    check_reset_outs("rm");
    send(8'h77, 1'b0, "rm_idle_nack");
    host_rd(8'h40, 8'h11, "rm_mem40");

    // Reset discards a pending write cycle
    start_c();
    send(8'hA0, 1'b1, "rb_dev");
    send(8'h41, 1'b1, "rb_waddr");
    send(8'h22, 1'b1, "rb_data");
    stop_c();
    chk("rb_busy", busy, 1'b1);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    chk("rb_busy_cleared", busy, 1'b0);
    repeat (3) @(negedge clk);
    chk("rb_busy_stays", busy, 1'b0);

    // Pointer is zero after reset
    start_c();
    send(8'hA1, 1'b1, "rp_devr");
    tx_read(8'h03, "rp_ptr0");
    nack_c();
    stop_c();

    // Sequential read wrap 0xFF -> 0x00, host read blocked by tx_req
    host_wr(8'hFF, 8'hAB);
    start_c();
    send(8'hA0, 1'b1, "sr_dev");
    send(8'hFF, 1'b1, "sr_waddr");
    start_c();
    send(8'hA1, 1'b1, "sr_devr");
    @(negedge clk); i2c_tx_req = 1'b1; host_req = 1'b1; host_we = 1'b0; host_addr = 8'h10;
    #1 chk("sr_blk", host_gnt, 1'b0);
    @(negedge clk); i2c_tx_req = 1'b0;
    #1 chk("sr_gnt", host_gnt, 1'b1);
    chk("sr_b0_early", i2c_tx_valid, 1'b0);
    @(negedge clk); host_req = 1'b0;
    chk("sr_rvalid", host_rvalid, 1'b1);
    chk("sr_rdata", host_rdata, 8'hC5);
    chk("sr_b0_valid", i2c_tx_valid, 1'b1);
    chk("sr_b0", i2c_tx_data, 8'hAB);
    tx_read(8'h03, "sr_b1");
    nack_c();
    @(negedge clk); i2c_tx_req = 1'b1;
    @(negedge clk); i2c_tx_req = 1'b0;
    n = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i2c_tx_valid) n++;
    end
    chk("sr_ignore_txreq", n, 0);
    chk("sr_txdata_hold", i2c_tx_data, 8'h03);
    stop_c();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
